// File: rtl/lsu_pkg.sv
// Shared types and decode helpers for the load/store memory master.
// Access-size and legality decode live here so every unit agrees on them.
package lsu_pkg;

  typedef enum logic [2:0] {
    CTRL_B  = 3'b000,
    CTRL_H  = 3'b001,
    CTRL_W  = 3'b010,
    CTRL_BU = 3'b100,
    CTRL_HU = 3'b101
  } mem_ctrl_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BEAT0 = 2'd1,
    ST_BEAT1 = 2'd2,
    ST_RESP  = 2'd3
  } lsu_state_e;

  function automatic logic [2:0] size_of(input logic [2:0] ctrl);
    logic [2:0] s;
    s = 3'd0;
    unique case (1'b1)
      (ctrl == CTRL_B),
      (ctrl == CTRL_BU): s = 3'd1;
      (ctrl == CTRL_H),
      (ctrl == CTRL_HU): s = 3'd2;
      (ctrl == CTRL_W):  s = 3'd4;
      default:           s = 3'd0;
    endcase
    return s;
  endfunction

  function automatic logic is_legal(
    input logic [2:0] ctrl,
    input logic       write
  );
    logic base;
    base = (ctrl == CTRL_B) || (ctrl == CTRL_H) ||
           (ctrl == CTRL_W);
    if (write) return base;
    return base || (ctrl == CTRL_BU) ||
           (ctrl == CTRL_HU);
  endfunction

endpackage

// File: rtl/lsu_mem_master_if.sv
// Core request/response and memory-bus bundle for lsu_mem_master.
// master = the LSU side; slave = the core plus memory responder side.
interface lsu_mem_master_if;

  logic        reqValid;
  logic        reqReady;
  logic        reqWrite;
  logic [2:0]  reqCtrl;
  logic [31:0] reqAddr;
  logic [31:0] reqWData;

  logic        respValid;
  logic        respError;
  logic [31:0] respRData;

  logic        memReq;
  logic        memWrite;
  logic [31:0] memAddr;
  logic [3:0]  memByteEn;
  logic [31:0] memWData;
  logic        memAck;
  logic [31:0] memRData;

  modport master (
    input  reqValid, reqWrite, reqCtrl,
    input  reqAddr, reqWData,
    input  memAck, memRData,
    output reqReady,
    output respValid, respError, respRData,
    output memReq, memWrite, memAddr,
    output memByteEn, memWData
  );

  modport slave (
    output reqValid, reqWrite, reqCtrl,
    output reqAddr, reqWData,
    output memAck, memRData,
    input  reqReady,
    input  respValid, respError, respRData,
    input  memReq, memWrite, memAddr,
    input  memByteEn, memWData
  );

endinterface

// File: rtl/lsu_align.sv
// Lane alignment: byte enables and store data for both beats,
// plus load-data realignment and sign/zero extension.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  ctrl_i,
  input  logic [1:0]  off_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rlo_i,
  input  logic [31:0] rhi_i,
  output logic [3:0]  en0_o,
  output logic [3:0]  en1_o,
  output logic [31:0] wd0_o,
  output logic [31:0] wd1_o,
  output logic        split_o,
  output logic [31:0] rdata_o
);

  logic [2:0]  size;
  logic [7:0]  base;
  logic [7:0]  mask;
  logic [31:0] wmask;
  logic [63:0] wide;
  logic [31:0] r;

  always_comb begin
    size  = size_of(ctrl_i);
    base  = 8'h00;
    wmask = 32'h0;
    unique case (1'b1)
      (size == 3'd1): begin
        base  = 8'h01;
        wmask = 32'h0000_00FF;
      end
      (size == 3'd2): begin
        base  = 8'h03;
        wmask = 32'h0000_FFFF;
      end
      (size == 3'd4): begin
        base  = 8'h0F;
        wmask = 32'hFFFF_FFFF;
      end
      default: ;
    endcase

    // Upper nibble of the mask is the spill into the next word.
    mask    = base << off_i;
    en0_o   = mask[3:0];
    en1_o   = mask[7:4];
    split_o = |mask[7:4];

    wide  = {32'b0, wdata_i & wmask} << {off_i, 3'b000};
    wd0_o = wide[31:0];
    wd1_o = wide[63:32];

    r = 32'({rhi_i, rlo_i} >> {off_i, 3'b000});
    rdata_o = 32'h0;
    unique case (1'b1)
      (ctrl_i == CTRL_B):  rdata_o = {{24{r[7]}}, r[7:0]};
      (ctrl_i == CTRL_H):  rdata_o = {{16{r[15]}}, r[15:0]};
      (ctrl_i == CTRL_W):  rdata_o = r;
      (ctrl_i == CTRL_BU): rdata_o = {24'b0, r[7:0]};
      (ctrl_i == CTRL_HU): rdata_o = {16'b0, r[15:0]};
      default:             rdata_o = 32'h0;
    endcase
  end

endmodule

// File: rtl/lsu_mem_master.sv
// Load/store initiator: one access at a time, split into up to two
// aligned word beats, with a single-cycle completion pulse.
module lsu_mem_master
  import lsu_pkg::*;
#(
  parameter bit SPLIT_MISALIGNED = 1'b1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  lsu_mem_master_if.master bus_io
);

  localparam logic [1:0] S_IDLE  = ST_IDLE;
  localparam logic [1:0] S_BEAT0 = ST_BEAT0;
  localparam logic [1:0] S_BEAT1 = ST_BEAT1;
  localparam logic [1:0] S_RESP  = ST_RESP;

  logic [1:0]  state_q, state_d;
  logic        write_q, write_d;
  logic [2:0]  ctrl_q, ctrl_d;
  logic [1:0]  off_q, off_d;
  logic [31:0] base_q, base_d;
  logic [31:0] wdata_q, wdata_d;
  logic        split_q, split_d;
  logic [31:0] rlo_q, rlo_d;
  logic        mreq_q, mreq_d;
  logic        mwr_q, mwr_d;
  logic [31:0] maddr_q, maddr_d;
  logic [3:0]  men_q, men_d;
  logic [31:0] mwd_q, mwd_d;
  logic        err_q, err_d;
  logic [31:0] rdata_q, rdata_d;

  logic        idle;
  logic [2:0]  a_ctrl;
  logic [1:0]  a_off;
  logic [31:0] a_wd;
  logic [31:0] a_rlo;
  logic [3:0]  en0, en1;
  logic [31:0] wd0, wd1;
  logic        split;
  logic [31:0] ext;

  // Idle: align the incoming request; busy: align the latched one.
  assign idle   = (state_q == S_IDLE);
  assign a_ctrl = idle ? bus_io.reqCtrl : ctrl_q;
  assign a_off  = idle ? bus_io.reqAddr[1:0] : off_q;
  assign a_wd   = idle ? bus_io.reqWData : wdata_q;
  assign a_rlo  = (state_q == S_BEAT1) ? rlo_q
                                       : bus_io.memRData;

  lsu_align u_align (
    .ctrl_i  (a_ctrl),
    .off_i   (a_off),
    .wdata_i (a_wd),
    .rlo_i   (a_rlo),
    .rhi_i   (bus_io.memRData),
    .en0_o   (en0),
    .en1_o   (en1),
    .wd0_o   (wd0),
    .wd1_o   (wd1),
    .split_o (split),
    .rdata_o (ext)
  );

  always_comb begin
    state_d = state_q;
    write_d = write_q;
    ctrl_d  = ctrl_q;
    off_d   = off_q;
    base_d  = base_q;
    wdata_d = wdata_q;
    split_d = split_q;
    rlo_d   = rlo_q;
    mreq_d  = mreq_q;
    mwr_d   = mwr_q;
    maddr_d = maddr_q;
    men_d   = men_q;
    mwd_d   = mwd_q;
    err_d   = err_q;
    rdata_d = rdata_q;
    case (state_q)
      S_IDLE: begin
        if (bus_io.reqValid) begin
          write_d = bus_io.reqWrite;
          ctrl_d  = bus_io.reqCtrl;
          off_d   = bus_io.reqAddr[1:0];
          base_d  = {bus_io.reqAddr[31:2], 2'b00};
          wdata_d = bus_io.reqWData;
          split_d = split;
          rdata_d = 32'h0;
          if (!is_legal(bus_io.reqCtrl, bus_io.reqWrite) ||
              (split && !SPLIT_MISALIGNED)) begin
            err_d   = 1'b1;
            state_d = S_RESP;
          end else begin
            err_d   = 1'b0;
            state_d = S_BEAT0;
            mreq_d  = 1'b1;
            mwr_d   = bus_io.reqWrite;
            maddr_d = {bus_io.reqAddr[31:2], 2'b00};
            men_d   = en0;
            mwd_d   = bus_io.reqWrite ? wd0 : 32'h0;
          end
        end
      end
      S_BEAT0: begin
        if (bus_io.memAck) begin
          if (split_q) begin
            // memReq stays high; the next beat follows directly.
            state_d = S_BEAT1;
            rlo_d   = bus_io.memRData;
            maddr_d = base_q + 32'd4;
            men_d   = en1;
            mwd_d   = write_q ? wd1 : 32'h0;
          end else begin
            state_d = S_RESP;
            mreq_d  = 1'b0;
            mwr_d   = 1'b0;
            maddr_d = 32'h0;
            men_d   = 4'h0;
            mwd_d   = 32'h0;
            rdata_d = write_q ? 32'h0 : ext;
          end
        end
      end
      S_BEAT1: begin
        if (bus_io.memAck) begin
          state_d = S_RESP;
          mreq_d  = 1'b0;
          mwr_d   = 1'b0;
          maddr_d = 32'h0;
          men_d   = 4'h0;
          mwd_d   = 32'h0;
          rdata_d = write_q ? 32'h0 : ext;
        end
      end
      default: begin
        state_d = S_IDLE;
        err_d   = 1'b0;
        rdata_d = 32'h0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      write_q <= 1'b0;
      ctrl_q  <= 3'h0;
      off_q   <= 2'h0;
      base_q  <= 32'h0;
      wdata_q <= 32'h0;
      split_q <= 1'b0;
      rlo_q   <= 32'h0;
      mreq_q  <= 1'b0;
      mwr_q   <= 1'b0;
      maddr_q <= 32'h0;
      men_q   <= 4'h0;
      mwd_q   <= 32'h0;
      err_q   <= 1'b0;
      rdata_q <= 32'h0;
    end else begin
      state_q <= state_d;
      write_q <= write_d;
      ctrl_q  <= ctrl_d;
      off_q   <= off_d;
      base_q  <= base_d;
      wdata_q <= wdata_d;
      split_q <= split_d;
      rlo_q   <= rlo_d;
      mreq_q  <= mreq_d;
      mwr_q   <= mwr_d;
      maddr_q <= maddr_d;
      men_q   <= men_d;
      mwd_q   <= mwd_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

  assign bus_io.reqReady  = idle;
  assign bus_io.respValid = (state_q == S_RESP);
  assign bus_io.respError = err_q;
  assign bus_io.respRData = rdata_q;
  assign bus_io.memReq    = mreq_q;
  assign bus_io.memWrite  = mwr_q;
  assign bus_io.memAddr   = maddr_q;
  assign bus_io.memByteEn = men_q;
  assign bus_io.memWData  = mwd_q;

endmodule

// File: tb/tb_lsu_mem_master.sv
// Directed and random bench for lsu_mem_master with a byte-array
// memory responder and a response scoreboard.
module tb_lsu_mem_master;
  import lsu_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  lsu_mem_master_if b1 ();
  lsu_mem_master_if b0 ();

  lsu_mem_master #(.SPLIT_MISALIGNED(1'b1)) dut1 (
    .clk_i (clk),
    .rst_i (rst),
    .bus_io(b1)
  );

  lsu_mem_master #(.SPLIT_MISALIGNED(1'b0)) dut0 (
    .clk_i (clk),
    .rst_i (rst),
    .bus_io(b0)
  );

  typedef struct {
    logic        err;
    logic [31:0] rd;
  } resp_t;

  typedef struct {
    logic [31:0] a;
    logic [3:0]  en;
    logic [31:0] wd;
    logic        wr;
  } beat_t;

  int tests = 0;
  int fails = 0;
  int ack_delay = 0;
  int wcnt = 0;
  int resp_cnt = 0;
  resp_t exp_q[$];
  beat_t beat_q[$];
  logic [7:0] ram  [logic [31:0]];
  logic [7:0] refm [logic [31:0]];

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] init_b(input logic [31:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h5A;
  endfunction

  function automatic logic [7:0] ram_rd(input logic [31:0] a);
    return ram.exists(a) ? ram[a] : init_b(a);
  endfunction

  function automatic logic [7:0] ref_rd(input logic [31:0] a);
    return refm.exists(a) ? refm[a] : init_b(a);
  endfunction

  function automatic logic [31:0] exp_load(input logic [2:0] c,
                                           input logic [31:0] a);
    logic [7:0] y0, y1, y2, y3;
    y0 = ref_rd(a);
    y1 = ref_rd(a + 32'd1);
    y2 = ref_rd(a + 32'd2);
    y3 = ref_rd(a + 32'd3);
    case (c)
      3'b000:  return {{24{y0[7]}}, y0};
      3'b001:  return {{16{y1[7]}}, y1, y0};
      3'b010:  return {y3, y2, y1, y0};
      3'b100:  return {24'b0, y0};
      3'b101:  return {16'b0, y1, y0};
      default: return 32'h0;
    endcase
  endfunction

  task automatic preload_word(input logic [31:0] a, input logic [31:0] w);
    for (int i = 0; i < 4; i++) begin
      ram[a + 32'(i)]  = w[8*i +: 8];
      refm[a + 32'(i)] = w[8*i +: 8];
    end
  endtask

  task automatic ref_store(input logic [2:0] c, input logic [31:0] a,
                           input logic [31:0] wd);
    int n;
    n = int'(size_of(c));
    for (int i = 0; i < n; i++) refm[a + 32'(i)] = wd[8*i +: 8];
  endtask

  // Memory responder and response monitor, both on the falling edge.
  initial begin
    beat_t bt;
    resp_t e;
    b1.memAck = 1'b0;
    b1.memRData = 32'h0;
    b0.memAck = 1'b0;
    b0.memRData = 32'h0;
    forever begin
      @(negedge clk);
      b1.memAck = 1'b0;
      if (rst || !b1.memReq) begin
        wcnt = 0;
      end else if (wcnt >= ack_delay) begin
        bt.a  = b1.memAddr;
        bt.en = b1.memByteEn;
        bt.wd = b1.memWData;
        bt.wr = b1.memWrite;
        beat_q.push_back(bt);
        chk("beat_addr_aligned", {30'b0, bt.a[1:0]}, 32'h0);
        if (bt.wr) begin
          for (int i = 0; i < 4; i++)
            if (bt.en[i]) ram[bt.a + 32'(i)] = bt.wd[8*i +: 8];
        end else begin
          b1.memRData = {ram_rd(bt.a + 32'd3), ram_rd(bt.a + 32'd2),
                         ram_rd(bt.a + 32'd1), ram_rd(bt.a)};
        end
        b1.memAck = 1'b1;
        wcnt = 0;
      end else begin
        wcnt++;
      end
      if (b1.respValid) begin
        resp_cnt++;
        chk("resp_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("resp_err", {31'b0, b1.respError}, {31'b0, e.err});
          chk("resp_rdata", b1.respRData, e.rd);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

  task automatic wait_ready;
    int n;
    n = 0;
    while (!b1.reqReady && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic drive(input logic w, input logic [2:0] c,
                       input logic [31:0] a, input logic [31:0] wd);
    wait_ready();
    b1.reqValid = 1'b1;
    b1.reqWrite = w;
    b1.reqCtrl  = c;
    b1.reqAddr  = a;
    b1.reqWData = wd;
    @(posedge clk); #1;
    b1.reqValid = 1'b0;
  endtask

  task automatic issue(input logic w, input logic [2:0] c,
                       input logic [31:0] a, input logic [31:0] wd,
                       input logic ee, input logic [31:0] er);
    resp_t e;
    e.err = ee;
    e.rd  = er;
    exp_q.push_back(e);
    drive(w, c, a, wd);
  endtask

  task automatic wait_resp(input int n0);
    int n;
    n = 0;
    while (resp_cnt == n0 && n < 60) begin
      @(posedge clk); #1;
      n++;
    end
    chk("resp_arrived", resp_cnt, n0 + 1);
  endtask

  task automatic chk_beat(input string tag, input int idx,
                          input logic [31:0] a, input logic [3:0] en,
                          input logic [31:0] wd, input logic wr);
    beat_t bt;
    chk({tag, "_present"}, 32'(beat_q.size() > idx), 32'd1);
    if (beat_q.size() > idx) begin
      bt = beat_q[idx];
      chk({tag, "_addr"}, bt.a, a);
      chk({tag, "_en"}, {28'b0, bt.en}, {28'b0, en});
      chk({tag, "_wdata"}, bt.wd, wd);
      chk({tag, "_write"}, {31'b0, bt.wr}, {31'b0, wr});
    end
  endtask

  initial begin
    int n0, nb, got;
    logic ge;
    logic [31:0] gr;
    logic w;
    logic [2:0] c;
    logic [31:0] a, wd;
    logic [2:0] ld_ctrls [5];
    ld_ctrls = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};

    rst = 1'b1;
    b1.reqValid = 1'b0; b1.reqWrite = 1'b0; b1.reqCtrl = 3'h0;
    b1.reqAddr = 32'h0; b1.reqWData = 32'h0;
    b0.reqValid = 1'b0; b0.reqWrite = 1'b0; b0.reqCtrl = 3'h0;
    b0.reqAddr = 32'h0; b0.reqWData = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_reqReady", {31'b0, b1.reqReady}, 32'd1);
    chk("rst_respValid", {31'b0, b1.respValid}, 32'd0);
    chk("rst_respError", {31'b0, b1.respError}, 32'd0);
    chk("rst_respRData", b1.respRData, 32'h0);
    chk("rst_memReq", {31'b0, b1.memReq}, 32'd0);
    chk("rst_memWrite", {31'b0, b1.memWrite}, 32'd0);
    chk("rst_memAddr", b1.memAddr, 32'h0);
    chk("rst_memByteEn", {28'b0, b1.memByteEn}, 32'h0);
    chk("rst_memWData", b1.memWData, 32'h0);
    rst = 1'b0;

    // Reset while beat0 is outstanding.
    ack_delay = 100;
    n0 = resp_cnt;
    nb = beat_q.size();
    drive(1'b0, 3'b010, 32'h100, 32'h0);
    chk("rstmid_memReq_on", {31'b0, b1.memReq}, 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rstmid_memReq_off", {31'b0, b1.memReq}, 32'd0);
    chk("rstmid_reqReady", {31'b0, b1.reqReady}, 32'd1);
    rst = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk("rstmid_no_resp", resp_cnt, n0);
    chk("rstmid_no_beat", beat_q.size(), nb);

    // Aligned LW, ack two cycles late.
    ack_delay = 2;
    preload_word(32'h100, 32'h8899_AABB);
    n0 = resp_cnt; nb = beat_q.size();
    issue(1'b0, 3'b010, 32'h100, 32'h0, 1'b0, 32'h8899_AABB);
    wait_resp(n0);
    chk("lw_beats", beat_q.size(), nb + 1);
    chk_beat("lw_b0", nb, 32'h100, 4'b1111, 32'h0, 1'b0);

    // LB / LBU at offset 3.
    ack_delay = 0;
    preload_word(32'h100, 32'h80FF_0011);
    n0 = resp_cnt; nb = beat_q.size();
    issue(1'b0, 3'b000, 32'h103, 32'h0, 1'b0, 32'hFFFF_FF80);
    wait_resp(n0);
    chk_beat("lb_b0", nb, 32'h100, 4'b1000, 32'h0, 1'b0);
    n0 = resp_cnt;
    issue(1'b0, 3'b100, 32'h103, 32'h0, 1'b0, 32'h0000_0080);
    wait_resp(n0);

    // Misaligned SW split into two beats.
    ack_delay = 1;
    n0 = resp_cnt; nb = beat_q.size();
    ref_store(3'b010, 32'h202, 32'h1122_3344);
    issue(1'b1, 3'b010, 32'h202, 32'h1122_3344, 1'b0, 32'h0);
    wait_resp(n0);
    chk("sw_beats", beat_q.size(), nb + 2);
    chk_beat("sw_b0", nb, 32'h200, 4'b1100, 32'h3344_0000, 1'b1);
    chk_beat("sw_b1", nb + 1, 32'h204, 4'b0011, 32'h0000_1122, 1'b1);

    // LH spanning a word boundary.
    preload_word(32'h0FC, 32'hAA00_0000);
    preload_word(32'h100, 32'h0000_00BB);
    n0 = resp_cnt; nb = beat_q.size();
    issue(1'b0, 3'b001, 32'h0FF, 32'h0, 1'b0, 32'hFFFF_BBAA);
    wait_resp(n0);
    chk_beat("lh_b0", nb, 32'h0FC, 4'b1000, 32'h0, 1'b0);
    chk_beat("lh_b1", nb + 1, 32'h100, 4'b0001, 32'h0, 1'b0);

    // Same LH on the non-splitting instance.
    chk("nosplit_ready", {31'b0, b0.reqReady}, 32'd1);
    b0.reqValid = 1'b1; b0.reqWrite = 1'b0;
    b0.reqCtrl = 3'b001; b0.reqAddr = 32'h0FF;
    @(posedge clk); #1;
    b0.reqValid = 1'b0;
    got = 0; ge = 1'b0; gr = 32'hDEAD_BEEF;
    for (int k = 0; k < 4; k++) begin
      chk("nosplit_no_memReq", {31'b0, b0.memReq}, 32'd0);
      if (b0.respValid) begin
        got++;
        ge = b0.respError;
        gr = b0.respRData;
      end
      @(posedge clk); #1;
    end
    chk("nosplit_resp_count", got, 1);
    chk("nosplit_err", {31'b0, ge}, 32'd1);
    chk("nosplit_rdata", gr, 32'h0);

    // Illegal control codes never reach the bus.
    nb = beat_q.size();
    n0 = resp_cnt;
    issue(1'b1, 3'b100, 32'h300, 32'hDEAD_BEEF, 1'b1, 32'h0);
    chk("ill_st_memReq", {31'b0, b1.memReq}, 32'd0);
    wait_resp(n0);
    n0 = resp_cnt;
    issue(1'b0, 3'b011, 32'h304, 32'h0, 1'b1, 32'h0);
    chk("ill_ld_memReq", {31'b0, b1.memReq}, 32'd0);
    wait_resp(n0);
    chk("ill_no_beats", beat_q.size(), nb);

    // Beat1 address wraps past the top of the address space.
    ack_delay = 0;
    n0 = resp_cnt; nb = beat_q.size();
    issue(1'b0, 3'b010, 32'hFFFF_FFFE, 32'h0, 1'b0,
          exp_load(3'b010, 32'hFFFF_FFFE));
    wait_resp(n0);
    chk_beat("wrap_b0", nb, 32'hFFFF_FFFC, 4'b1100, 32'h0, 1'b0);
    chk_beat("wrap_b1", nb + 1, 32'h0000_0000, 4'b0011, 32'h0, 1'b0);

    // Minimum latency with an immediate ack.
    n0 = resp_cnt;
    issue(1'b0, 3'b010, 32'h400, 32'h0, 1'b0, exp_load(3'b010, 32'h400));
    chk("minlat_memReq", {31'b0, b1.memReq}, 32'd1);
    @(posedge clk); #1;
    chk("minlat_respValid", {31'b0, b1.respValid}, 32'd1);
    wait_resp(n0);

    // reqValid while busy is not queued.
    ack_delay = 3;
    n0 = resp_cnt; nb = beat_q.size();
    issue(1'b0, 3'b010, 32'h500, 32'h0, 1'b0, exp_load(3'b010, 32'h500));
    b1.reqValid = 1'b1; b1.reqAddr = 32'h600;
    chk("busy_not_ready", {31'b0, b1.reqReady}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    b1.reqValid = 1'b0;
    wait_resp(n0);
    repeat (4) @(posedge clk);
    #1;
    chk("busy_one_resp", resp_cnt, n0 + 1);
    chk("busy_one_beat", beat_q.size(), nb + 1);

    // Random aligned/misaligned stream against the byte-array model.
    for (int t = 0; t < 40; t++) begin
      ack_delay = int'($urandom_range(0, 3));
      w  = 1'($urandom_range(0, 1));
      a  = 32'h1000 + 32'($urandom_range(0, 63));
      wd = $urandom;
      n0 = resp_cnt;
      if (w) begin
        c = 3'($urandom_range(0, 2));
        ref_store(c, a, wd);
        issue(1'b1, c, a, wd, 1'b0, 32'h0);
      end else begin
        c = ld_ctrls[$urandom_range(0, 4)];
        issue(1'b0, c, a, 32'h0, 1'b0, exp_load(c, a));
      end
      wait_resp(n0);
    end

    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
